// File: rtl/memory_order_violation_controller_pkg.sv
// Shared load/store-unit types for the memory-order violation controller:
// FSM state encoding, the MDP update record and the load-queue age helper.
package memory_order_violation_controller_pkg;

  localparam int LSU_LQ_ENTRY_NUM = 16;
  localparam int LSU_LQ_PTR_W     = $clog2(LSU_LQ_ENTRY_NUM);
  localparam int LSU_PC_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RECOVER = 2'd2
  } MemOrderViolationState;

  typedef struct packed {
    logic [LSU_PC_WIDTH-1:0] loadPC;
    logic [LSU_PC_WIDTH-1:0] storePC;
  } MdpUpdateEntry;

  // Distance of ptr from the queue head; smaller means older. The extra
  // bit lets a pointer that has wrapped past the end sort after the head.
  function automatic logic [LSU_LQ_PTR_W:0] lq_age(
    input logic [LSU_LQ_PTR_W-1:0] ptr,
    input logic [LSU_LQ_PTR_W-1:0] head
  );
    logic [LSU_LQ_PTR_W:0] ext;
    ext = {1'b0, ptr};
    if (ptr < head) begin
      ext = ext + (LSU_LQ_PTR_W+1)'(LSU_LQ_ENTRY_NUM);
    end
    return ext - {1'b0, head};
  endfunction

endpackage

// File: rtl/memory_order_violation_controller_mdp_update_fifo.sv
// Small circular buffer of predictor-training updates. The head entry is
// driven straight from storage registers, so a push is visible one cycle
// later at the earliest. A push while full is accepted only if the head is
// popped in the same cycle.
module mdp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop_en;
  logic             push_en;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Write one storage slot when the write pointer lands on it.
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_en && !pop_en)      count_reg <= count_reg + 1'b1;
      else if (pop_en && !push_en) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/memory_order_violation_controller.sv
// Picks the oldest violating store each cycle, holds a refetch request to
// the recovery manager under req/ack until recovery completes, and queues
// {loadPC, storePC} pairs for the memory dependence predictor.
module memory_order_violation_controller
  import memory_order_violation_controller_pkg::*;
#(
  parameter int LQ_ENTRY_NUM   = LSU_LQ_ENTRY_NUM,
  parameter int STORE_WIDTH    = 2,
  parameter int PC_WIDTH       = LSU_PC_WIDTH,
  parameter int MDP_FIFO_DEPTH = 4,
  localparam int LQ_PTR_W      = $clog2(LQ_ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STORE_WIDTH-1:0]          conflict,
  input  logic [STORE_WIDTH*PC_WIDTH-1:0] conflictLoadPC,
  input  logic [STORE_WIDTH*PC_WIDTH-1:0] storePC,
  input  logic [STORE_WIDTH*LQ_PTR_W-1:0] storeLqPtr,
  input  logic [LQ_PTR_W-1:0]             lqHeadPtr,
  input  logic                            externalFlush,
  output logic                            recoveryReq,
  output logic [LQ_PTR_W-1:0]             recoveryLqPtr,
  output logic [PC_WIDTH-1:0]             recoveryStorePC,
  input  logic                            recoveryAck,
  input  logic                            recoveryDone,
  output logic                            mdpWriteValid,
  output logic [PC_WIDTH-1:0]             mdpWriteLoadPC,
  output logic [PC_WIDTH-1:0]             mdpWriteStorePC,
  input  logic                            mdpWriteReady,
  output logic                            busy,
  output logic [7:0]                      mdpDropCount
);

  MemOrderViolationState state_reg;
  logic                  req_reg;
  logic [LQ_PTR_W-1:0]   cap_ptr_reg;
  logic [PC_WIDTH-1:0]   cap_spc_reg;
  logic [7:0]            drop_reg;

  logic [LQ_PTR_W:0]     lane_age [STORE_WIDTH];
  logic                  win_valid;
  logic [LQ_PTR_W:0]     win_age;
  logic [LQ_PTR_W-1:0]   win_ptr;
  logic [PC_WIDTH-1:0]   win_spc;
  logic [PC_WIDTH-1:0]   win_lpc;
  logic [LQ_PTR_W:0]     cap_age;
  logic                  capture;
  logic                  replace;
  logic                  push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  MdpUpdateEntry         push_entry;
  MdpUpdateEntry         head_entry;

  genvar gi;
  generate
    for (gi = 0; gi < STORE_WIDTH; gi++) begin : g_lane_age
      assign lane_age[gi] = lq_age(storeLqPtr[gi*LQ_PTR_W +: LQ_PTR_W], lqHeadPtr);
    end
  endgenerate

  // Oldest conflicting lane; strict compare keeps ties on the lower lane.
  always_comb begin
    win_valid = 1'b0;
    win_age   = '0;
    win_ptr   = '0;
    win_spc   = '0;
    win_lpc   = '0;
    for (int i = 0; i < STORE_WIDTH; i++) begin
      if (conflict[i] && (!win_valid || (lane_age[i] < win_age))) begin
        win_valid = 1'b1;
        win_age   = lane_age[i];
        win_ptr   = storeLqPtr[i*LQ_PTR_W +: LQ_PTR_W];
        win_spc   = storePC[i*PC_WIDTH +: PC_WIDTH];
        win_lpc   = conflictLoadPC[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  // The held capture is re-aged against the current head every cycle.
  assign cap_age = lq_age(cap_ptr_reg, lqHeadPtr);
  assign capture = !externalFlush && (state_reg == IDLE) && win_valid;
  assign replace = !externalFlush && (state_reg == REQ) && !recoveryAck &&
                   win_valid && (win_age < cap_age);
  assign push    = capture || replace;

  // Recovery sequencing and capture registers; flush overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_reg     <= 1'b0;
      cap_ptr_reg <= '0;
      cap_spc_reg <= '0;
    end else if (externalFlush) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (capture) begin
            state_reg   <= REQ;
            req_reg     <= 1'b1;
            cap_ptr_reg <= win_ptr;
            cap_spc_reg <= win_spc;
          end
        end
        REQ: begin
          if (recoveryAck) begin
            state_reg <= RECOVER;
            req_reg   <= 1'b0;
          end else if (replace) begin
            cap_ptr_reg <= win_ptr;
            cap_spc_reg <= win_spc;
          end
        end
        RECOVER: begin
          if (recoveryDone) state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of training updates lost to a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_reg <= '0;
    end else if (push && fifo_full && !fifo_pop && (drop_reg != 8'hFF)) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  assign push_entry.loadPC  = win_lpc;
  assign push_entry.storePC = win_spc;
  assign fifo_pop           = mdpWriteValid && mdpWriteReady;

  mdp_update_fifo #(
    .DEPTH (MDP_FIFO_DEPTH),
    .WIDTH ($bits(MdpUpdateEntry))
  ) u_mdp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

  assign recoveryReq     = req_reg;
  assign recoveryLqPtr   = cap_ptr_reg;
  assign recoveryStorePC = cap_spc_reg;
  assign busy            = (state_reg != IDLE);
  assign mdpDropCount    = drop_reg;
  assign mdpWriteValid   = !fifo_empty;
  assign mdpWriteLoadPC  = head_entry.loadPC;
  assign mdpWriteStorePC = head_entry.storePC;

endmodule

// File: tb/tb_memory_order_violation_controller.sv
// Directed bench: request/handshake checks inline, MDP updates through a
// scoreboard queue drained by a monitor whenever the predictor consumes.
module tb_memory_order_violation_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  conflict;
  logic [63:0] conflictLoadPC;
  logic [63:0] storePC;
  logic [7:0]  storeLqPtr;
  logic [3:0]  lqHeadPtr;
  logic        externalFlush;
  logic        recoveryReq;
  logic [3:0]  recoveryLqPtr;
  logic [31:0] recoveryStorePC;
  logic        recoveryAck;
  logic        recoveryDone;
  logic        mdpWriteValid;
  logic [31:0] mdpWriteLoadPC;
  logic [31:0] mdpWriteStorePC;
  logic        mdpWriteReady;
  logic        busy;
  logic [7:0]  mdpDropCount;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  memory_order_violation_controller dut (
    .clk(clk), .rst(rst), .conflict(conflict), .conflictLoadPC(conflictLoadPC),
    .storePC(storePC), .storeLqPtr(storeLqPtr), .lqHeadPtr(lqHeadPtr),
    .externalFlush(externalFlush), .recoveryReq(recoveryReq),
    .recoveryLqPtr(recoveryLqPtr), .recoveryStorePC(recoveryStorePC),
    .recoveryAck(recoveryAck), .recoveryDone(recoveryDone),
    .mdpWriteValid(mdpWriteValid), .mdpWriteLoadPC(mdpWriteLoadPC),
    .mdpWriteStorePC(mdpWriteStorePC), .mdpWriteReady(mdpWriteReady),
    .busy(busy), .mdpDropCount(mdpDropCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    conflict      = '0;
    externalFlush = 1'b0;
    recoveryAck   = 1'b0;
    recoveryDone  = 1'b0;
  endtask

  task automatic lane(input int l, input logic [3:0] p, input logic [31:0] lpc, input logic [31:0] spc);
    conflict[l]             = 1'b1;
    storeLqPtr[l*4 +: 4]    = p;
    conflictLoadPC[l*32 +: 32] = lpc;
    storePC[l*32 +: 32]     = spc;
  endtask

  task automatic expect_push(input logic [31:0] lpc, input logic [31:0] spc);
    exp_q.push_back({lpc, spc});
  endtask

  // Predictor side: every consumed head entry must match the oldest expected update.
  always @(negedge clk) begin
    if (!rst && mdpWriteValid && mdpWriteReady) begin
      logic [63:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      $display("MDP pop load=%h store=%h", mdpWriteLoadPC, mdpWriteStorePC);
      checks++;
      assert ({mdpWriteLoadPC, mdpWriteStorePC} === e) else begin
        errors++;
        $error("FAIL mdp_entry: observed %h expected %h", {mdpWriteLoadPC, mdpWriteStorePC}, e);
      end
    end
  end

  initial begin
    rst = 1'b1; idle_inputs(); conflictLoadPC = '0; storePC = '0; storeLqPtr = '0;
    lqHeadPtr = '0; mdpWriteReady = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(recoveryReq), 0);
    chk("rst_ptr", 32'(recoveryLqPtr), 0);
    chk("rst_spc", recoveryStorePC, 0);
    chk("rst_valid", 32'(mdpWriteValid), 0);
    chk("rst_mdp_lpc", mdpWriteLoadPC, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(mdpDropCount), 0);
    rst = 1'b0; tick();
    $display("T1 lane0 conflict ptr=5 head=2");
    lqHeadPtr = 4'd2; lane(0, 4'd5, 32'hA100, 32'hB100); expect_push(32'hA100, 32'hB100);
    tick(); idle_inputs();
    chk("t1_req", 32'(recoveryReq), 1);
    chk("t1_ptr", 32'(recoveryLqPtr), 5);
    chk("t1_spc", recoveryStorePC, 32'hB100);
    chk("t1_valid", 32'(mdpWriteValid), 1);
    recoveryAck = 1'b1; tick(); idle_inputs();
    chk("t1_ack_req", 32'(recoveryReq), 0);
    chk("t1_recover_busy", 32'(busy), 1);
    recoveryDone = 1'b1; tick(); idle_inputs();
    chk("t1_done_busy", 32'(busy), 0);
    $display("T2 oldest lane wins across wrap (head=12)");
    lqHeadPtr = 4'd12; lane(0, 4'd3, 32'hA200, 32'hB200); lane(1, 4'd14, 32'hA201, 32'hB201);
    expect_push(32'hA201, 32'hB201);
    tick(); idle_inputs();
    chk("t2_ptr", 32'(recoveryLqPtr), 14);
    chk("t2_spc", recoveryStorePC, 32'hB201);
    externalFlush = 1'b1; tick(); idle_inputs();
    chk("t2_flush_req", 32'(recoveryReq), 0);
    $display("T2 equal ages, lane0 wins");
    lane(0, 4'd6, 32'hA300, 32'hB300); lane(1, 4'd6, 32'hA301, 32'hB301);
    expect_push(32'hA300, 32'hB300);
    tick(); idle_inputs();
    chk("t2_tie_spc", recoveryStorePC, 32'hB300);
    externalFlush = 1'b1; tick(); idle_inputs();
    $display("T3 older replacement in REQ (head=0)");
    lqHeadPtr = 4'd0; lane(1, 4'd9, 32'hA400, 32'hB400); expect_push(32'hA400, 32'hB400);
    tick(); idle_inputs();
    chk("t3_ptr9", 32'(recoveryLqPtr), 9);
    lane(0, 4'd4, 32'hA401, 32'hB401); expect_push(32'hA401, 32'hB401);
    tick(); idle_inputs();
    chk("t3_ptr4", 32'(recoveryLqPtr), 4);
    chk("t3_spc4", recoveryStorePC, 32'hB401);
    chk("t3_req", 32'(recoveryReq), 1);
    lane(0, 4'd11, 32'hA402, 32'hB402);
    tick(); idle_inputs();
    chk("t3_younger_kept", 32'(recoveryLqPtr), 4);
    $display("T4 ack -> RECOVER, conflicts ignored");
    recoveryAck = 1'b1; tick(); idle_inputs();
    chk("t4_req", 32'(recoveryReq), 0);
    lane(0, 4'd1, 32'hA403, 32'hB403);
    tick(); idle_inputs();
    chk("t4_rec_ptr", 32'(recoveryLqPtr), 4);
    chk("t4_rec_req", 32'(recoveryReq), 0);
    chk("t4_rec_busy", 32'(busy), 1);
    recoveryDone = 1'b1; tick(); idle_inputs();
    chk("t4_idle_busy", 32'(busy), 0);
    $display("T5 flush with ack, FIFO kept");
    mdpWriteReady = 1'b0;
    lane(0, 4'd7, 32'hA500, 32'hB500); expect_push(32'hA500, 32'hB500);
    tick(); idle_inputs();
    chk("t5_req", 32'(recoveryReq), 1);
    externalFlush = 1'b1; recoveryAck = 1'b1; lane(0, 4'd2, 32'hA501, 32'hB501);
    tick(); idle_inputs();
    chk("t5_req_drop", 32'(recoveryReq), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_fifo_valid", 32'(mdpWriteValid), 1);
    chk("t5_fifo_lpc", mdpWriteLoadPC, 32'hA500);
    tick();
    chk("t5_still_idle", 32'(busy), 0);
    mdpWriteReady = 1'b1; tick(); mdpWriteReady = 1'b0;
    chk("t5_drained", 32'(mdpWriteValid), 0);
    $display("T6 overflow with ready=0");
    for (int k = 0; k < 5; k++) begin
      lane(0, 4'(15 - k), 32'hA600 + 32'(k), 32'hB600 + 32'(k));
      if (k < 4) expect_push(32'hA600 + 32'(k), 32'hB600 + 32'(k));
      tick();
    end
    idle_inputs();
    chk("t6_drop1", 32'(mdpDropCount), 1);
    chk("t6_ptr", 32'(recoveryLqPtr), 11);
    chk("t6_head", mdpWriteLoadPC, 32'hA600);
    mdpWriteReady = 1'b1; lane(0, 4'd10, 32'hA610, 32'hB610); expect_push(32'hA610, 32'hB610);
    tick(); idle_inputs();
    chk("t6_pushpop_drop", 32'(mdpDropCount), 1);
    mdpWriteReady = 1'b0; lane(0, 4'd9, 32'hA611, 32'hB611);
    tick(); idle_inputs();
    chk("t6_still_full_drop2", 32'(mdpDropCount), 2);
    mdpWriteReady = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_empty", 32'(mdpWriteValid), 0);
    chk("t6_scoreboard", 32'(exp_q.size()), 0);
    $display("T7 reset in REQ");
    externalFlush = 1'b1; tick(); idle_inputs();
    mdpWriteReady = 1'b0;
    lane(0, 4'd3, 32'hA700, 32'hB700);
    tick(); idle_inputs();
    chk("t7_req", 32'(recoveryReq), 1);
    rst = 1'b1; exp_q.delete(); tick();
    chk("t7_rst_req", 32'(recoveryReq), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_ptr", 32'(recoveryLqPtr), 0);
    chk("t7_rst_valid", 32'(mdpWriteValid), 0);
    chk("t7_rst_drop", 32'(mdpDropCount), 0);
    rst = 1'b0; tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
